// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage 16-bit core: resolves load-use, memory wait-state,
// taken-branch and halt-drain hazards, and keeps a stall-cycle counter and memory-timeout flag.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ID_Rs,
    input  logic [3:0]       ID_Rt,
    input  logic             ID_ReadsRs,
    input  logic             ID_ReadsRt,
    input  logic             ID_BranchTaken,
    input  logic             ID_Halt,
    input  logic             EX_MemtoReg,
    input  logic             EX_RegWrite,
    input  logic [3:0]       EX_Rd,
    input  logic             MEM_MemAccess,
    input  logic             mem_ready,
    input  logic             if_ready,
    output logic             pc_wen,
    output logic             IF_ID_wen,
    output logic             IF_ID_flush,
    output logic             ID_EX_wen,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_wen,
    output logic             MEM_WB_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // wait_cnt only has to reach MEM_TIMEOUT-1 before it saturates.
    localparam int              WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [1:0]      DRAIN_LEN  = 2'd3;

    state_t             state_q, state_d;
    logic [1:0]         drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               halted_q, halted_d;

    logic load_use;
    logic dstall;
    logic timeout_en;

    logic pc_wen_c, if_id_wen_c, if_id_flush_c, id_ex_wen_c;
    logic id_ex_bubble_c, ex_mem_wen_c, mem_wb_bubble_c;

    assign timeout_en = (MEM_TIMEOUT != 0);

    assign load_use = EX_MemtoReg && EX_RegWrite && (EX_Rd != 4'd0) &&
                      ((ID_ReadsRs && (ID_Rs == EX_Rd)) || (ID_ReadsRt && (ID_Rt == EX_Rd)));

    assign dstall = MEM_MemAccess && !mem_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        pc_wen_c        = 1'b1;
        if_id_wen_c     = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_wen_c     = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_wen_c    = 1'b1;
        mem_wb_bubble_c = 1'b0;
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;

        unique case (state_q)
            RUN: begin
                if (dstall) begin
                    pc_wen_c        = 1'b0;
                    if_id_wen_c     = 1'b0;
                    id_ex_wen_c     = 1'b0;
                    ex_mem_wen_c    = 1'b0;
                    mem_wb_bubble_c = 1'b1;
                end else if (load_use) begin
                    // Load-use beats a taken branch: the branch re-resolves with the loaded operand.
                    pc_wen_c       = 1'b0;
                    if_id_wen_c    = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end else if (!if_ready && !ID_BranchTaken) begin
                    pc_wen_c      = 1'b0;
                    if_id_flush_c = 1'b1;
                end else if (ID_BranchTaken) begin
                    if_id_flush_c = 1'b1;
                end else if (ID_Halt) begin
                    pc_wen_c      = 1'b0;
                    if_id_flush_c = 1'b1;
                    state_d       = DRAIN;
                    drain_cnt_d   = DRAIN_LEN;
                end
            end
            DRAIN: begin
                pc_wen_c      = 1'b0;
                if_id_flush_c = 1'b1;
                if (dstall) begin
                    if_id_wen_c     = 1'b0;
                    id_ex_wen_c     = 1'b0;
                    ex_mem_wen_c    = 1'b0;
                    mem_wb_bubble_c = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                    if (drain_cnt_q == 2'd1) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                pc_wen_c     = 1'b0;
                if_id_wen_c  = 1'b0;
                id_ex_wen_c  = 1'b0;
                ex_mem_wen_c = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        halted_d = (state_d == HALTED);

        wait_cnt_d = '0;
        if (dstall) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        // The timeout is a sticky flag only; it never changes the stall decisions above.
        mem_timeout_d = mem_timeout_q || (timeout_en && dstall && (wait_cnt_q == WAIT_LIMIT));

        stall_cnt_d = stall_cnt_q;
        if (!pc_wen_c && (state_q != HALTED) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            drain_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            halted_q      <= halted_d;
        end
    end

    // Reset forces every pipeline control inactive without waiting for a clock edge.
    assign pc_wen        = pc_wen_c        && !rst;
    assign IF_ID_wen     = if_id_wen_c     && !rst;
    assign IF_ID_flush   = if_id_flush_c   && !rst;
    assign ID_EX_wen     = id_ex_wen_c     && !rst;
    assign ID_EX_bubble  = id_ex_bubble_c  && !rst;
    assign EX_MEM_wen    = ex_mem_wen_c    && !rst;
    assign MEM_WB_bubble = mem_wb_bubble_c && !rst;

    assign halted      = halted_q;
    assign stall_cnt   = stall_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage 16-bit core.
- Generates write-enable and bubble/flush controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use hazards, instruction/data memory wait states, taken-branch flushes and halt draining.
- Also provides a stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64: consecutive data-memory wait cycles before mem_timeout sets; 0 disables the check.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- ID_Rs  input  4  source register 1 of the instruction in ID
- ID_Rt  input  4  source register 2 of the instruction in ID
- ID_ReadsRs  input  1  ID instruction reads Rs
- ID_ReadsRt  input  1  ID instruction reads Rt
- ID_BranchTaken  input  1  branch resolved taken in ID
- ID_Halt  input  1  HLT opcode in ID
- EX_MemtoReg  input  1  load in EX
- EX_RegWrite  input  1  EX instruction writes the register file
- EX_Rd  input  4  destination register of the EX instruction
- MEM_MemAccess  input  1  load or store in MEM
- mem_ready  input  1  data memory completes the access this cycle
- if_ready  input  1  instruction memory has valid fetch data this cycle
- pc_wen  output  1  PC update enable
- IF_ID_wen  output  1  IF_ID write enable
- IF_ID_flush  output  1  IF_ID loads a NOP instead of the fetched word
- ID_EX_wen  output  1  ID_EX write enable
- ID_EX_bubble  output  1  ID_EX loads zeroed control fields
- EX_MEM_wen  output  1  EX_MEM write enable
- MEM_WB_bubble  output  1  MEM_WB loads zeroed control fields
- halted  output  1  pipeline drained after HLT
- stall_cnt  output  CNT_W  saturating count of stalled cycles
- mem_timeout  output  1  sticky; data-memory wait exceeded MEM_TIMEOUT

Behaviour:
- States: RUN, DRAIN, HALTED. Reset (async, rst=1) gives state=RUN, drain_cnt=0, wait_cnt=0, stall_cnt=0, mem_timeout=0, halted=0.
- While rst=1, all *_wen=0 and all flush/bubble outputs=0.
- Combinational outputs depend on state and inputs; no added latency.
- load_use = EX_MemtoReg & EX_RegWrite & (EX_Rd!=0) & ((ID_ReadsRs & ID_Rs==EX_Rd) | (ID_ReadsRt & ID_Rt==EX_Rd)).
- dstall = MEM_MemAccess & ~mem_ready.
- Defaults: all wen=1, flush/bubble=0.
- Priority in RUN (first match wins):
  - dstall: pc_wen, IF_ID_wen, ID_EX_wen and EX_MEM_wen all 0; MEM_WB_bubble=1.
  - load_use: pc_wen=0, IF_ID_wen=0, ID_EX_bubble=1; EX and MEM advance.
  - ~if_ready & ~ID_BranchTaken: pc_wen=0, IF_ID_flush=1.
  - ID_BranchTaken (whether or not if_ready): pc_wen=1, IF_ID_flush=1.
  - ID_Halt: pc_wen=0, IF_ID_flush=1; next state DRAIN with drain_cnt=3.
- DRAIN:
  - pc_wen=0 and IF_ID_flush=1 every cycle.
  - dstall freezes as in RUN and holds drain_cnt.
  - Otherwise drain_cnt decrements; when drain_cnt=1, next state is HALTED.
- HALTED: all wen=0, halted=1. Only rst leaves HALTED.
- wait_cnt:
  - Increments on each dstall cycle, saturating; clears on any non-dstall cycle.
  - When MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT-1 during dstall, mem_timeout is set on that edge.
  - mem_timeout is sticky until rst; it is a flag only and does not alter stalling.
- stall_cnt increments on every cycle with pc_wen=0 while state!=HALTED and rst=0. It saturates at all ones, with no wrap.
- Simultaneous events:
  - load_use and ID_BranchTaken together: load_use wins. The branch re-resolves next cycle with the forwarded operand.
  - dstall and ID_Halt together: freeze; halt is taken once dstall clears.
- Reset mid-stall or mid-drain returns to RUN immediately; counters clear.

Test Plan:
- Reset, then if_ready=mem_ready=1 with no hazards for 10 cycles -> all wen=1, all flush/bubble=0, stall_cnt=0.
- EX_MemtoReg=1, EX_RegWrite=1, EX_Rd=5, ID_Rs=5, ID_ReadsRs=1 for 1 cycle -> pc_wen=0, IF_ID_wen=0, ID_EX_bubble=1, stall_cnt=1. Repeat with EX_Rd=0 -> no stall.
- MEM_MemAccess=1 with mem_ready held 0 for 4 cycles, then 1 -> 4 frozen cycles with MEM_WB_bubble=1, then all wen=1; stall_cnt=4. With MEM_TIMEOUT=3 -> mem_timeout rises after the 3rd wait cycle and stays 1.
- ID_BranchTaken=1 with if_ready=0 -> pc_wen=1, IF_ID_flush=1. Add load_use in the same cycle -> pc_wen=0, ID_EX_bubble=1.
- ID_Halt=1 in RUN -> 3 DRAIN cycles with pc_wen=0, then halted=1 and all wen=0. A dstall during DRAIN lengthens the drain by the dstall length.
- Assert rst in DRAIN and while stall_cnt=7 -> state RUN, halted=0, stall_cnt=0, mem_timeout=0 immediately, without waiting for clk.
